// File: rtl/render_frame_source_if.sv
// Config-write and render-stream bus between the frame source and its neighbours.
// master: the frame source (accepts config, drives the stream); slave: host/downstream side.
interface render_frame_source_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [10:0] cfg_stage;
    logic [11:0] cfg_reg;
    logic [31:0] cfg_data;
    logic        program_out;
    logic [10:0] x_out;
    logic [11:0] y_out;
    logic [31:0] data_out;
    logic        pixel_valid;

    modport master (
        input  cfg_valid, cfg_stage, cfg_reg, cfg_data,
        output cfg_ready, program_out, x_out, y_out, data_out, pixel_valid
    );
    modport slave (
        output cfg_valid, cfg_stage, cfg_reg, cfg_data,
        input  cfg_ready, program_out, x_out, y_out, data_out, pixel_valid
    );
endinterface

// File: rtl/render_frame_source.sv
// Head of the render chain: drains queued shape-register writes as program beats, then one frame of bg pixels.
// Optional RENDER_FRAME_SOURCE_AUTORUN_EN: frames run back to back from reset, start ignored.
module render_frame_source #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [31:0]                 bg_color,
    render_frame_source_if.master       bus,
    output logic                        busy,
    output logic                        frame_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [10:0] X_LAST = 11'(H_RES - 1);
    localparam logic [11:0] Y_LAST = 12'(V_RES - 1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [10:0] stage;
        logic [11:0] rid;
        logic [31:0] data;
    } cfg_t;

    typedef enum logic [1:0] {IDLE, PROG, SCAN} state_t;

    cfg_t          mem [FIFO_DEPTH];
    cfg_t          head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_n;
    logic          push, pop, empty;

    state_t        state, state_n;
    logic          emit_prog, emit_pix, latch_bg, last_pix, start_eff;
    logic [10:0]   x_cnt;
    logic [11:0]   y_cnt;
    logic [31:0]   bg_lat;

`ifdef RENDER_FRAME_SOURCE_AUTORUN_EN
    assign start_eff = 1'b1;
`else
    assign start_eff = start;
`endif

    assign push     = bus.cfg_valid && bus.cfg_ready;
    assign empty    = (count == '0);
    assign head     = mem[rd_ptr];
    assign count_n  = count + (AW+1)'(push) - (AW+1)'(pop);
    assign last_pix = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{stage: bus.cfg_stage, rid: bus.cfg_reg, data: bus.cfg_data};
    end

    // PROG with an empty queue emits pixel (0,0) itself so the raster follows the last program beat without a gap.
    always_comb begin
        state_n   = state;
        pop       = 1'b0;
        emit_prog = 1'b0;
        emit_pix  = 1'b0;
        latch_bg  = 1'b0;
        case (state)
            IDLE: if (start_eff) begin
                latch_bg = 1'b1;
                state_n  = empty ? SCAN : PROG;
            end
            PROG: if (!empty) begin
                pop       = 1'b1;
                emit_prog = 1'b1;
            end else begin
                emit_pix  = 1'b1;
            end
            SCAN:    emit_pix = 1'b1;
            default: state_n  = IDLE;
        endcase
        if (emit_pix) begin
            state_n = SCAN;
            if (last_pix) begin
`ifdef RENDER_FRAME_SOURCE_AUTORUN_EN
                latch_bg = 1'b1;
                state_n  = (count_n == '0) ? SCAN : PROG;
`else
                state_n  = IDLE;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            bus.cfg_ready   <= 1'b1;
            x_cnt           <= '0;
            y_cnt           <= '0;
            bg_lat          <= '0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            bus.program_out <= 1'b1;
            bus.x_out       <= 11'h7FF;
            bus.y_out       <= 12'hFFF;
            bus.data_out    <= '0;
            bus.pixel_valid <= 1'b0;
        end else begin
            state         <= state_n;
            count         <= count_n;
            bus.cfg_ready <= (count_n != FULL_CNT);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (latch_bg) bg_lat <= bg_color;
            busy       <= emit_prog || emit_pix;
            frame_done <= emit_pix && last_pix;

            if (emit_prog) begin
                bus.program_out <= 1'b1;
                bus.x_out       <= head.stage;
                bus.y_out       <= head.rid;
                bus.data_out    <= head.data;
                bus.pixel_valid <= 1'b0;
            end else if (emit_pix) begin
                bus.program_out <= 1'b0;
                bus.x_out       <= x_cnt;
                bus.y_out       <= y_cnt;
                bus.data_out    <= bg_lat;
                bus.pixel_valid <= 1'b1;
            end else begin
                // Stage index 2047 never matches a real renderer, so this beat is inert.
                bus.program_out <= 1'b1;
                bus.x_out       <= 11'h7FF;
                bus.y_out       <= 12'hFFF;
                bus.data_out    <= '0;
                bus.pixel_valid <= 1'b0;
            end

            if (emit_pix) begin
                if (x_cnt == X_LAST) begin
                    x_cnt <= '0;
                    y_cnt <= last_pix ? '0 : y_cnt + 1'b1;
                end else begin
                    x_cnt <= x_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_render_frame_source.sv
// Directed bench for render_frame_source with a 4x2 frame and a 16-entry config queue.
module tb_render_frame_source;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] bg_color = '0;
    logic        busy, frame_done;
    int          checks = 0;
    int          errors = 0;

    localparam logic [56:0] IDLE_BEAT = {1'b1, 11'h7FF, 12'hFFF, 32'h0, 1'b0};

    render_frame_source_if bus();

    render_frame_source #(.H_RES(4), .V_RES(2), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bg_color(bg_color),
        .bus(bus), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [56:0] beat();
        return {bus.program_out, bus.x_out, bus.y_out, bus.data_out, bus.pixel_valid};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [10:0] s, input logic [11:0] r, input logic [31:0] d);
        bus.cfg_valid = 1'b1;
        bus.cfg_stage = s;
        bus.cfg_reg   = r;
        bus.cfg_data  = d;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy === 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0 || beat() !== IDLE_BEAT) begin
            errors++;
            $display("FAIL %s frame end: busy=%b beat=%h want busy=0 beat=%h", name, busy, beat(), IDLE_BEAT);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (beat() !== IDLE_BEAT) begin
            errors++; $display("FAIL reset beat: got %h want %h", beat(), IDLE_BEAT);
        end
        checks++;
        if ({busy, frame_done, bus.cfg_ready} !== 3'b001) begin
            errors++; $display("FAIL reset flags: busy/done/ready=%b want 001", {busy, frame_done, bus.cfg_ready});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_program();
        bg_color = 32'hAABBCCDD;
        push(11'd0, 12'd0, 32'd100);
        push(11'd2, 12'd4, 32'hFF00FF00);
        pulse_start();
        checks++;
        if (beat() !== IDLE_BEAT || busy !== 1'b0) begin
            errors++; $display("FAIL prog E0 beat: got %h busy=%b want idle", beat(), busy);
        end
        tick();
        checks++;
        if (beat() !== {1'b1, 11'd0, 12'd0, 32'd100, 1'b0} || busy !== 1'b1) begin
            errors++; $display("FAIL prog beat0: got %h busy=%b", beat(), busy);
        end
        tick();
        checks++;
        if (beat() !== {1'b1, 11'd2, 12'd4, 32'hFF00FF00, 1'b0}) begin
            errors++; $display("FAIL prog beat1: got %h", beat());
        end
        tick();
        checks++;
        if (beat() !== {1'b0, 11'd0, 12'd0, 32'hAABBCCDD, 1'b1}) begin
            errors++; $display("FAIL prog first pixel: got %h", beat());
        end
        wait_idle("prog");
    endtask

    task automatic test_raster();
        bg_color = 32'h11223344;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (beat() !== {1'b0, 11'(i % 4), 12'(i / 4), 32'h11223344, 1'b1} ||
                frame_done !== (i == 7) || busy !== 1'b1) begin
                errors++;
                $display("FAIL raster pixel %0d: got %h done=%b busy=%b", i, beat(), frame_done, busy);
            end
        end
        tick();
        checks++;
        if (beat() !== IDLE_BEAT || busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++; $display("FAIL raster after: got %h busy=%b done=%b want idle", beat(), busy, frame_done);
        end
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < 16; i++) begin
            push(11'(i), 12'(i % 5), 32'(1000 + i));
            if (i == 14) begin
                checks++;
                if (bus.cfg_ready !== 1'b1) begin
                    errors++; $display("FAIL fifo ready at 15: got %b want 1", bus.cfg_ready);
                end
            end
        end
        checks++;
        if (bus.cfg_ready !== 1'b0) begin
            errors++; $display("FAIL fifo full ready: got %b want 0", bus.cfg_ready);
        end
        bus.cfg_valid = 1'b1;
        bus.cfg_stage = 11'd16;
        bus.cfg_reg   = 12'd1;
        bus.cfg_data  = 32'd1016;
        repeat (2) tick();
        checks++;
        if (bus.cfg_ready !== 1'b0) begin
            errors++; $display("FAIL fifo held ready: got %b want 0", bus.cfg_ready);
        end
        bg_color = 32'h0;
        pulse_start();
        for (int i = 0; i < 17; i++) begin
            tick();
            if (i == 1) bus.cfg_valid = 1'b0;
            if (i == 0) begin
                checks++;
                if (bus.cfg_ready !== 1'b1) begin
                    errors++; $display("FAIL fifo ready after pop: got %b want 1", bus.cfg_ready);
                end
            end
            checks++;
            if (beat() !== {1'b1, 11'(i), 12'(i % 5), 32'(1000 + i), 1'b0}) begin
                errors++; $display("FAIL fifo beat %0d: got %h", i, beat());
            end
        end
        tick();
        checks++;
        if (beat() !== {1'b0, 11'd0, 12'd0, 32'h0, 1'b1}) begin
            errors++; $display("FAIL fifo first pixel: got %h", beat());
        end
        wait_idle("fifo");
    endtask

    task automatic test_scan_push();
        bg_color = 32'h00C0FFEE;
        pulse_start();
        tick();
        pulse_start();
        push(11'd1, 12'd2, 32'd50);
        checks++;
        if (beat() !== {1'b0, 11'd2, 12'd0, 32'h00C0FFEE, 1'b1}) begin
            errors++; $display("FAIL scan pixel2: got %h", beat());
        end
        for (int i = 3; i < 8; i++) begin
            tick();
            checks++;
            if (beat() !== {1'b0, 11'(i % 4), 12'(i / 4), 32'h00C0FFEE, 1'b1}) begin
                errors++; $display("FAIL scan pixel %0d: got %h", i, beat());
            end
        end
        checks++;
        if (frame_done !== 1'b1) begin
            errors++; $display("FAIL scan done: got %b want 1", frame_done);
        end
        repeat (2) tick();
        checks++;
        if (beat() !== IDLE_BEAT || busy !== 1'b0) begin
            errors++; $display("FAIL scan start ignored: got %h busy=%b want idle", beat(), busy);
        end
        pulse_start();
        tick();
        checks++;
        if (beat() !== {1'b1, 11'd1, 12'd2, 32'd50, 1'b0}) begin
            errors++; $display("FAIL scan queued beat: got %h", beat());
        end
        tick();
        checks++;
        if (beat() !== {1'b0, 11'd0, 12'd0, 32'h00C0FFEE, 1'b1}) begin
            errors++; $display("FAIL scan next pixel0: got %h", beat());
        end
        wait_idle("scan");
    endtask

    task automatic test_reset_midscan();
        bg_color = 32'h55AA55AA;
        pulse_start();
        tick();
        push(11'd3, 12'd0, 32'd1);
        push(11'd4, 12'd1, 32'd2);
        push(11'd5, 12'd2, 32'd3);
        rst_n = 1'b0;
        tick();
        checks++;
        if (beat() !== IDLE_BEAT || busy !== 1'b0 || bus.cfg_ready !== 1'b1) begin
            errors++; $display("FAIL midscan reset: got %h busy=%b ready=%b", beat(), busy, bus.cfg_ready);
        end
        rst_n = 1'b1;
        tick();
        pulse_start();
        tick();
        checks++;
        if (beat() !== {1'b0, 11'd0, 12'd0, 32'h55AA55AA, 1'b1}) begin
            errors++; $display("FAIL midscan restart pixel0: got %h", beat());
        end
        wait_idle("midscan");
    endtask

    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_stage = '0;
        bus.cfg_reg   = '0;
        bus.cfg_data  = '0;
        test_reset();
        test_program();
        test_raster();
        test_fifo_full();
        test_scan_push();
        test_reset_midscan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
